// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared constants and types for the EX->MEM pipeline stage register.
package ex_mem_stage_reg_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CTRL_W_DEF = 4;

    // Control-bit positions within the ctrl vector
    localparam int unsigned CTRL_WBSRC    = 0;
    localparam int unsigned CTRL_REGWRITE = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMREAD  = 3;

    // Occupancy of the main/skid entry pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// EX->MEM handshake bus: EX drives in_* and out_ready, the stage drives in_ready and out_*.
interface ex_mem_stage_reg_if #(
    parameter int unsigned DATA_W = ex_mem_stage_reg_pkg::DATA_W_DEF,
    parameter int unsigned REG_AW = ex_mem_stage_reg_pkg::REG_AW_DEF,
    parameter int unsigned CTRL_W = ex_mem_stage_reg_pkg::CTRL_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_store_data;
    logic [REG_AW-1:0] in_rd;
    logic [REG_AW-1:0] in_rs2;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_alu_result;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_AW-1:0] out_rd;
    logic [REG_AW-1:0] out_rs2;

    modport master (
        output in_valid, in_ctrl, in_alu_result, in_store_data, in_rd, in_rs2, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu_result, out_store_data, out_rd, out_rs2
    );

    modport slave (
        input  in_valid, in_ctrl, in_alu_result, in_store_data, in_rd, in_rs2, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu_result, out_store_data, out_rd, out_rs2
    );
endinterface

// File: rtl/ex_mem_stage_reg_entry.sv
// One pipeline entry: valid, control and payload. Clearing drops valid and ctrl but keeps the payload.
module ex_mem_stage_reg_entry #(
    parameter int unsigned CTRL_W    = 4,
    parameter int unsigned PAYLOAD_W = 74
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [CTRL_W-1:0]    d_ctrl,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output logic                 valid,
    output logic [CTRL_W-1:0]    ctrl,
    output logic [PAYLOAD_W-1:0] payload
);

    // Clear wins over load so flush squashes a concurrent accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid   <= 1'b0;
            ctrl    <= '0;
            payload <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            ctrl    <= d_ctrl;
            payload <= d_payload;
        end
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM stage register with valid/ready handshake, flush, bubble clearing and optional skid entry.
module ex_mem_stage_reg #(
    parameter int unsigned DATA_W  = ex_mem_stage_reg_pkg::DATA_W_DEF,
    parameter int unsigned REG_AW  = ex_mem_stage_reg_pkg::REG_AW_DEF,
    parameter int unsigned CTRL_W  = ex_mem_stage_reg_pkg::CTRL_W_DEF,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    ex_mem_stage_reg_if.slave bus
);
    import ex_mem_stage_reg_pkg::*;

    localparam int unsigned PAYLOAD_W = 2 * DATA_W + 2 * REG_AW;

    stage_state_e         state, state_next;
    logic                 accept_c, drain_c, ready;
    logic                 main_load, main_clear, main_from_skid;
    logic                 skid_load, skid_clear;
    logic                 main_valid, skid_valid;
    logic [CTRL_W-1:0]    main_ctrl, skid_ctrl;
    logic [PAYLOAD_W-1:0] main_payload, skid_payload, in_payload;

    assign in_payload = {bus.in_alu_result, bus.in_store_data, bus.in_rd, bus.in_rs2};
    assign accept_c   = bus.in_valid & ready;
    assign drain_c    = main_valid & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_next;
    end

    // Next-state and entry enables; flush overrides any handshake activity
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: if (accept_c) begin
                    main_load  = 1'b1;
                    state_next = ST_FULL;
                end
                ST_FULL: begin
                    if (accept_c && drain_c) begin
                        main_load = 1'b1;
                    end else if (accept_c) begin
                        skid_load  = 1'b1;
                        state_next = ST_SKID;
                    end else if (drain_c) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_SKID: if (drain_c) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    state_next     = ST_FULL;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    ex_mem_stage_reg_entry #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W)) u_main (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .d_ctrl    (main_from_skid ? skid_ctrl : bus.in_ctrl),
        .d_payload (main_from_skid ? skid_payload : in_payload),
        .valid     (main_valid),
        .ctrl      (main_ctrl),
        .payload   (main_payload)
    );

    // Skid entry makes in_ready a pure register; without it ready looks through to out_ready
    generate
        if (SKID_EN) begin : g_skid
            ex_mem_stage_reg_entry #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W)) u_skid (
                .clk       (clk),
                .reset     (reset),
                .load      (skid_load),
                .clear     (skid_clear),
                .d_ctrl    (bus.in_ctrl),
                .d_payload (in_payload),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .payload   (skid_payload)
            );
            assign ready = ~skid_valid;
        end else begin : g_no_skid
            logic skid_unused;
            assign skid_valid   = 1'b0;
            assign skid_ctrl    = '0;
            assign skid_payload = '0;
            assign skid_unused  = skid_load ^ skid_clear ^ skid_valid;
            assign ready        = ~main_valid | bus.out_ready;
        end
    endgenerate

    assign bus.in_ready  = ready;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_ctrl;
    assign {bus.out_alu_result, bus.out_store_data, bus.out_rd, bus.out_rs2} = main_payload;

endmodule
